// File: rtl/mp_ooo_sram_pkg.sv
// mp_ooo_sram_pkg: shared state encoding and parameter checks for the mp_ooo SRAM model
package mp_ooo_sram_pkg;
  typedef enum logic {SRAM_CLEAR, SRAM_IDLE} sram_state_e;
  function automatic bit rl_legal(input int rl);
    return rl == 1 || rl == 2;
  endfunction
endpackage

// File: rtl/mp_ooo_sram_rd_pipe.sv
// mp_ooo_sram_rd_pipe: one valid/data register stage of the read-response pipeline
module mp_ooo_sram_rd_pipe #(
  parameter int W = 256
) (
  input  logic         clk0,
  input  logic         rst_n,
  input  logic         v_i,
  input  logic [W-1:0] d_i,
  output logic         v_o,
  output logic [W-1:0] d_o
);
  logic         v_q;
  logic [W-1:0] d_q;
  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_i;
      if (v_i) d_q <= d_i;
    end
  assign v_o = v_q;
  assign d_o = d_q;
endmodule

// File: rtl/mp_ooo_sram_array.sv
// mp_ooo_sram_array: masked single-port SRAM model with 1/2-cycle reads and a zeroing clear engine
module mp_ooo_sram_array
  import mp_ooo_sram_pkg::*;
#(
  parameter  int DATA_WIDTH     = 256,
  parameter  int ADDR_WIDTH     = 4,
  parameter  int WMASK_GRAN     = 8,
  parameter  int READ_LATENCY   = 1,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int RAM_DEPTH      = 1 << ADDR_WIDTH,
  localparam int NUM_WMASKS     = DATA_WIDTH / WMASK_GRAN
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  clr0,
  output logic                  ready0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] dout0
);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  if (!rl_legal(READ_LATENCY)) begin : g_bad_rl
    $error("mp_ooo_sram_array: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $error("mp_ooo_sram_array: DATA_WIDTH must be a multiple of WMASK_GRAN");
  end

  sram_state_e                     state_q, state_d;
  logic [ADDR_WIDTH:0]             cnt_q, cnt_d;
  logic                            ready_q, ready_d;
  logic                            accept, rd_acc, we;
  logic [ADDR_WIDTH-1:0]           waddr;
  logic [DATA_WIDTH-1:0]           wdata;
  logic [NUM_WMASKS-1:0]           wmask;
  logic [DATA_WIDTH-1:0]           mem_q [RAM_DEPTH];
  logic                            v0_q;
  logic [DATA_WIDTH-1:0]           d0_q;
  logic [READ_LATENCY-1:0]         v_s;
  logic [READ_LATENCY*DATA_WIDTH-1:0] d_s;

  always_comb begin
    accept  = ready_q && !csb0 && !clr0;
    rd_acc  = accept && web0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SRAM_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = SRAM_IDLE;
        cnt_d   = '0;
      end
    end else if (ready_q && clr0) begin
      state_d = SRAM_CLEAR;
    end
    ready_d = state_d == SRAM_IDLE;
    // the clear engine owns the single write port whenever it is running
    we      = state_q == SRAM_CLEAR ? rst_n : accept && !web0;
    waddr   = state_q == SRAM_CLEAR ? cnt_q[ADDR_WIDTH-1:0] : addr0;
    wdata   = state_q == SRAM_CLEAR ? '0 : din0;
    wmask   = state_q == SRAM_CLEAR ? '1 : wmask0;
  end

  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? SRAM_CLEAR : SRAM_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      v0_q    <= 1'b0;
      d0_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      v0_q    <= rd_acc;
      if (rd_acc) d0_q <= mem_q[addr0];
    end

  always_ff @(posedge clk0)
    for (int i = 0; i < NUM_WMASKS; i++)
      if (we && wmask[i]) mem_q[waddr][i*WMASK_GRAN +: WMASK_GRAN] <= wdata[i*WMASK_GRAN +: WMASK_GRAN];

  assign v_s[0]              = v0_q;
  assign d_s[DATA_WIDTH-1:0] = d0_q;
  for (genvar k = 1; k < READ_LATENCY; k++) begin : g_pipe
    mp_ooo_sram_rd_pipe #(.W(DATA_WIDTH)) u_pipe (
      .clk0 (clk0),
      .rst_n(rst_n),
      .v_i  (v_s[k-1]),
      .d_i  (d_s[(k-1)*DATA_WIDTH +: DATA_WIDTH]),
      .v_o  (v_s[k]),
      .d_o  (d_s[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign ready0  = ready_q;
  assign rvalid0 = v_s[READ_LATENCY-1];
  assign dout0   = d_s[(READ_LATENCY-1)*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: tb/tb_mp_ooo_sram_array.sv
// tb_mp_ooo_sram_array: vector table, directed corner sequences and random traffic vs. a memory model
module tb_mp_ooo_sram_array;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         csb = 1'b1, web = 1'b1, clr = 1'b0;
  logic [31:0]  wmask = '0;
  logic [3:0]   addr = '0;
  logic [255:0] din = '0;
  logic         ready_a, rvalid_a, ready_b, rvalid_b;
  logic [255:0] dout_a, dout_b;

  int n_cmp = 0, n_fail = 0;

  logic [255:0] ref_mem [16];
  int           clear_left;
  logic         m_ready, m_rv1, m_rv2;
  logic [255:0] m_d1, m_d2;

  always #5 clk = ~clk;

  mp_ooo_sram_array #(.READ_LATENCY(1)) dut_a (
    .clk0(clk), .rst_n(rst_n), .csb0(csb), .web0(web), .wmask0(wmask), .addr0(addr),
    .din0(din), .clr0(clr), .ready0(ready_a), .rvalid0(rvalid_a), .dout0(dout_a));

  mp_ooo_sram_array #(.READ_LATENCY(2)) dut_b (
    .clk0(clk), .rst_n(rst_n), .csb0(csb), .web0(web), .wmask0(wmask), .addr0(addr),
    .din0(din), .clr0(clr), .ready0(ready_b), .rvalid0(rvalid_b), .dout0(dout_b));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_a", 256'(ready_a), 256'(m_ready));
    chk("ready_b", 256'(ready_b), 256'(m_ready));
    chk("rvalid_a", 256'(rvalid_a), 256'(m_rv1));
    chk("rvalid_b", 256'(rvalid_b), 256'(m_rv2));
    chk("dout_a", dout_a, m_d1);
    chk("dout_b", dout_b, m_d2);
  endtask

  // reference: an array with a countdown clear; a read's data is fixed at accept and delivered after latency
  task automatic model_edge();
    logic rd = 1'b0;
    if (m_rv1) m_d2 = m_d1;
    m_rv2 = m_rv1;
    if (clear_left > 0) begin
      ref_mem[16-clear_left] = '0;
      clear_left--;
      m_ready = clear_left == 0;
    end else if (m_ready) begin
      if (clr) begin
        clear_left = 16;
        m_ready = 1'b0;
      end else if (!csb && web) begin
        rd = 1'b1;
        m_d1 = ref_mem[addr];
      end else if (!csb) begin
        for (int i = 0; i < 32; i++)
          if (wmask[i]) ref_mem[addr][i*8 +: 8] = din[i*8 +: 8];
      end
    end
    m_rv1 = rd;
  endtask

  task automatic step(input logic c, input logic w, input logic [31:0] m, input logic [3:0] a,
                      input logic [255:0] dd, input logic cl);
    csb = c; web = w; wmask = m; addr = a; din = dd; clr = cl;
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_left = 16; m_ready = 1'b0; m_rv1 = 1'b0; m_rv2 = 1'b0; m_d1 = '0; m_d2 = '0;
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_clear(input string nm, output logic saw_rv);
    int n = 0;
    saw_rv = 1'b0;
    while (!ready_a && n < 40) begin
      idle();
      saw_rv |= rvalid_a | rvalid_b;
      n++;
    end
    chk(nm, 256'(n), 256'd16);
  endtask

  typedef struct {
    logic c, w; logic [31:0] m; logic [3:0] a; logic [255:0] d; logic cl;
    logic erv; logic [255:0] edout;
  } vec_t;

  initial begin
    vec_t tbl[13];
    logic saw;
    logic [255:0] pd;
    logic prv;
    tbl[0]  = '{1'b0, 1'b1, 32'h0,        4'd5, 256'h0,       1'b0, 1'b1, 256'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 4'd3, {32{8'hA5}},  1'b0, 1'b0, 256'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h1,        4'd3, {32{8'hFF}},  1'b0, 1'b0, 256'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,        4'd3, 256'h0,       1'b0, 1'b1, {{31{8'hA5}}, 8'hFF}};
    tbl[4]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 4'd9, 256'h7,       1'b0, 1'b0, {{31{8'hA5}}, 8'hFF}};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,        4'd9, 256'h0,       1'b0, 1'b1, 256'h7};
    tbl[6]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 4'd1, 256'h11,      1'b0, 1'b0, 256'h7};
    tbl[7]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 4'd2, 256'h22,      1'b0, 1'b0, 256'h7};
    tbl[8]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 4'd3, 256'h33,      1'b0, 1'b0, 256'h7};
    tbl[9]  = '{1'b0, 1'b1, 32'h0,        4'd1, 256'h0,       1'b0, 1'b1, 256'h11};
    tbl[10] = '{1'b0, 1'b1, 32'h0,        4'd2, 256'h0,       1'b0, 1'b1, 256'h22};
    tbl[11] = '{1'b0, 1'b1, 32'h0,        4'd3, 256'h0,       1'b0, 1'b1, 256'h33};
    tbl[12] = '{1'b1, 1'b1, 32'h0,        4'd0, 256'h0,       1'b0, 1'b0, 256'h33};
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    count_clear("reset_clear_len", saw);

    prv = 1'b0; pd = '0;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].c, tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].cl);
      chk($sformatf("tbl%0d_rvalid_a", i), 256'(rvalid_a), 256'(tbl[i].erv));
      chk($sformatf("tbl%0d_dout_a", i), dout_a, tbl[i].edout);
      chk($sformatf("tbl%0d_rvalid_b", i), 256'(rvalid_b), 256'(prv));
      chk($sformatf("tbl%0d_dout_b", i), dout_b, pd);
      prv = tbl[i].erv; pd = tbl[i].edout;
    end

    step(1'b0, 1'b0, 32'hFFFFFFFF, 4'd0, 256'h55, 1'b0);
    step(1'b0, 1'b1, 32'h0, 4'd0, 256'h0, 1'b0);
    step(1'b0, 1'b0, 32'hFFFFFFFF, 4'd0, 256'h99, 1'b1);
    chk("preclr_read_b_valid", 256'(rvalid_b), 256'd1);
    chk("preclr_read_b_data", dout_b, 256'h55);
    chk("clr_ready_low", 256'(ready_a), 256'd0);
    count_clear("clr_len", saw);
    step(1'b0, 1'b1, 32'h0, 4'd0, 256'h0, 1'b0);
    chk("post_clr_addr0", dout_a, 256'h0);

    step(1'b1, 1'b1, 32'h0, 4'd0, 256'h0, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    do_reset();
    count_clear("midclr_reset_len", saw);

    step(1'b0, 1'b0, 32'hFFFFFFFF, 4'd6, 256'hBEEF, 1'b0);
    step(1'b0, 1'b1, 32'h0, 4'd6, 256'h0, 1'b0);
    do_reset();
    count_clear("inflight_reset_len", saw);
    chk("inflight_read_dropped", 256'(saw), 256'd0);

    for (int n = 0; n < 600; n++) begin
      logic [255:0] rd;
      for (int j = 0; j < 8; j++) rd[j*32 +: 32] = $urandom;
      if ($urandom_range(249) == 0) do_reset();
      else step($urandom_range(9) < 3, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)),
                rd, $urandom_range(59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
